im_boot_loader: RTL and testbench

Instruction-memory boot loader that sits between an external load stream and the IM SRAM_wrapper port, ahead of the CPU. It is the writer for the memory the CPU only reads. It holds the CPU in reset, accepts a word stream over a valid/ready handshake, and writes each word to sequential IM addresses from 0. It then reads the image back, compares checksums, and releases the CPU only on a match.

---
 rtl/im_boot_loader.sv | 187 ++++++++++++++++++
 tb/tb_im_boot_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_boot_loader.sv
// im_boot_loader: writes an incoming word stream into instruction memory from
// address 0, reads the image back, and releases the CPU only when the readback
// sum matches the sum of the accepted words.
//
// Handshake: a stream word transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready is 1 only in LOAD and does not depend on
// in_valid. in_data is ignored on all other edges.
module im_boot_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  word_count,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  sram_ceb,
    output logic                  sram_web,
    output logic [DATA_WIDTH-1:0] sram_bweb,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_di,
    input  logic [DATA_WIDTH-1:0] sram_do,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic [2:0]            dbg_state
);

    // Address counters carry one extra bit so a full 2^ADDR_WIDTH image
    // ends on the last address without wrapping.
    localparam int AW1 = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FLUSH  = 3'd2,
        S_VERIFY = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_n;
    logic [AW1-1:0]        r_addr;
    logic [AW1-1:0]        r_raddr;
    logic [DATA_WIDTH-1:0] r_checksum;
    logic [DATA_WIDTH-1:0] r_rsum;
    logic                  r_rd_pend;
    logic                  r_sram_ceb;
    logic                  r_sram_web;
    logic [DATA_WIDTH-1:0] r_sram_bweb;
    logic [ADDR_WIDTH-1:0] r_sram_a;
    logic [DATA_WIDTH-1:0] r_sram_di;
    logic                  r_cpu_hold;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic [CNT_WIDTH-1:0]  w_n_m1;
    logic                  w_last_beat;
    logic                  w_rd_all;
    logic [DATA_WIDTH-1:0] w_rsum_nxt;

    // Last-beat and all-reads-issued decodes; readback adds sram_do only on
    // the cycle after a read was on the port.
    assign w_n_m1      = r_n - CNT_WIDTH'(1);
    assign w_last_beat = (CNT_WIDTH'(r_addr) == w_n_m1);
    assign w_rd_all    = (CNT_WIDTH'(r_raddr) == r_n);
    assign w_rsum_nxt  = r_rsum + (r_rd_pend ? sram_do : '0);

    assign in_ready  = (r_state == S_LOAD);
    assign sram_ceb  = r_sram_ceb;
    assign sram_web  = r_sram_web;
    assign sram_bweb = r_sram_bweb;
    assign sram_a    = r_sram_a;
    assign sram_di   = r_sram_di;
    assign cpu_hold  = r_cpu_hold;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign checksum  = r_checksum;
    assign dbg_state = r_state;

    // Loader FSM with registered SRAM port and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_addr      <= '0;
            r_raddr     <= '0;
            r_checksum  <= '0;
            r_rsum      <= '0;
            r_rd_pend   <= 1'b0;
            r_sram_ceb  <= 1'b1;
            r_sram_web  <= 1'b1;
            r_sram_bweb <= '1;
            r_sram_a    <= '0;
            r_sram_di   <= '0;
            r_cpu_hold  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            // Port idles unless a state below schedules an access.
            r_sram_ceb  <= 1'b1;
            r_sram_web  <= 1'b1;
            r_sram_bweb <= '1;
            r_sram_a    <= '0;
            r_sram_di   <= '0;
            // A read on the port this cycle returns data next cycle.
            r_rd_pend   <= ~r_sram_ceb & r_sram_web;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n        <= word_count;
                        r_addr     <= '0;
                        r_checksum <= '0;
                        r_rsum     <= '0;
                        if (word_count == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_sram_ceb  <= 1'b0;
                        r_sram_web  <= 1'b0;
                        r_sram_bweb <= '0;
                        r_sram_a    <= r_addr[ADDR_WIDTH-1:0];
                        r_sram_di   <= in_data;
                        r_checksum  <= r_checksum + in_data;
                        r_addr      <= r_addr + AW1'(1);
                        if (w_last_beat) begin
                            r_state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // Address 0 is issued here so reads fill the N cycles
                    // of VERIFY; the counter restarts at the next address.
                    r_sram_ceb <= 1'b0;
                    r_sram_a   <= '0;
                    r_raddr    <= AW1'(1);
                    r_rsum     <= '0;
                    r_state    <= S_VERIFY;
                end
                S_VERIFY: begin
                    r_rsum <= w_rsum_nxt;
                    if (w_rd_all) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_sram_ceb <= 1'b0;
                        r_sram_a   <= r_raddr[ADDR_WIDTH-1:0];
                        r_raddr    <= r_raddr + AW1'(1);
                    end
                end
                S_CHECK: begin
                    r_rsum  <= w_rsum_nxt;
                    r_state <= (w_rsum_nxt == r_checksum) ? S_DONE : S_ERROR;
                end
                S_DONE: begin
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_cpu_hold <= 1'b0;
                end
                S_ERROR: begin
                    r_error    <= 1'b1;
                    r_busy     <= 1'b0;
                    r_cpu_hold <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_boot_loader.sv
// Bench for im_boot_loader: SRAM model with optional read corruption, a port
// monitor logging every access, and directed/random loads checked against a
// word-list reference (expected writes, reads, sum and timing).
module tb_im_boot_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [14:0] word_count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        sram_ceb;
    logic        sram_web;
    logic [31:0] sram_bweb;
    logic [13:0] sram_a;
    logic [31:0] sram_di;
    logic [31:0] sram_do;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit flip_a2 = 1'b0;

    logic [31:0] mem [0:16383];
    logic [31:0] stim_q[$];
    logic [31:0] wr_a_q[$];
    logic [31:0] wr_d_q[$];
    logic [31:0] wr_b_q[$];
    int          wr_c_q[$];
    logic [31:0] rd_a_q[$];
    logic [31:0] rd_b_q[$];
    int          rd_c_q[$];
    int          acc_c_q[$];

    im_boot_loader dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb),
        .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .checksum(checksum), .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: one-cycle read latency, bit-masked writes
    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_web)
                mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_di & ~sram_bweb);
            else
                sram_do <= mem[sram_a] ^ ((flip_a2 && sram_a == 14'd2) ? 32'h1 : 32'h0);
        end
    end

    // Port monitor
    always @(negedge clk) begin
        if (rst && !sram_ceb) begin
            if (!sram_web) begin
                wr_a_q.push_back(32'(sram_a));
                wr_d_q.push_back(sram_di);
                wr_b_q.push_back(sram_bweb);
                wr_c_q.push_back(cyc);
            end else begin
                rd_a_q.push_back(32'(sram_a));
                rd_b_q.push_back(sram_bweb);
                rd_c_q.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h state=%0d", tag, obs, exp, dbg_state);
        end
    endtask

    task automatic clear_logs();
        wr_a_q.delete(); wr_d_q.delete(); wr_b_q.delete(); wr_c_q.delete();
        rd_a_q.delete(); rd_b_q.delete(); rd_c_q.delete(); acc_c_q.delete();
    endtask

    // Assert reset away from the clock edge and check the values take effect at once
    task automatic reset_mid();
        #2;
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_ceb", sram_ceb, 1);
        chk("rst_web", sram_web, 1);
        chk("rst_bweb", sram_bweb, 32'hFFFF_FFFF);
        chk("rst_a", sram_a, 0);
        chk("rst_di", sram_di, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        flip_a2 = 1'b0;
    endtask

    // Load stim_q and follow the image through write, readback and result.
    // gap_mode: 0 back-to-back, 1 two idle cycles before each word, 2 random 0..3.
    task automatic run_load(input int n, input int gap_mode, input bit flip);
        logic [31:0] exp_sum;
        int lat;
        int g;
        int last_c;
        exp_sum = 32'h0;
        foreach (stim_q[i]) exp_sum += stim_q[i];
        clear_logs();
        flip_a2 = flip;
        start = 1'b1;
        word_count = 15'(n);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_in_load", busy, 1);
        chk("cpu_hold_in_load", cpu_hold, 1);
        for (int i = 0; i < n; i++) begin
            g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : $urandom_range(0, 3);
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                in_data = $urandom;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data = stim_q[i];
            if (i == 0) chk("in_ready_load", in_ready, 1);
            @(posedge clk); #1;
            acc_c_q.push_back(cyc);
        end
        in_valid = 1'b0;
        in_data = $urandom;
        chk("in_ready_flush", in_ready, 0);
        lat = 0;
        while (!(done || error) && lat < 4 * n + 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("result_latency", lat, n + 3);
        chk("done", done, flip ? 0 : 1);
        chk("error", error, flip ? 1 : 0);
        chk("cpu_hold_end", cpu_hold, flip ? 1 : 0);
        chk("busy_end", busy, 0);
        chk("checksum", checksum, exp_sum);
        last_c = acc_c_q[n-1];
        chk("wr_count", wr_a_q.size(), n);
        for (int i = 0; i < n && i < wr_a_q.size(); i++) begin
            chk("wr_addr", wr_a_q[i], i);
            chk("wr_data", wr_d_q[i], stim_q[i]);
            chk("wr_bweb", wr_b_q[i], 0);
            chk("wr_cycle", wr_c_q[i], acc_c_q[i]);
        end
        chk("rd_count", rd_a_q.size(), n);
        for (int i = 0; i < n && i < rd_a_q.size(); i++) begin
            chk("rd_addr", rd_a_q[i], i);
            chk("rd_bweb", rd_b_q[i], 32'hFFFF_FFFF);
            chk("rd_cycle", rd_c_q[i], last_c + 1 + i);
        end
    endtask

    task automatic fill_random(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back($urandom);
    endtask

    initial begin
        int n;
        logic [31:0] w0;
        logic [31:0] w1;
        rst = 1'b0;
        start = 1'b0;
        word_count = '0;
        in_valid = 1'b0;
        in_data = '0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;

        // Four fixed words back-to-back
        stim_q.delete();
        stim_q.push_back(32'h11); stim_q.push_back(32'h22);
        stim_q.push_back(32'h33); stim_q.push_back(32'h44);
        run_load(4, 0, 1'b0);
        chk("checksum_aa", checksum, 32'hAA);

        // start in DONE is ignored
        clear_logs();
        start = 1'b1; word_count = 15'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("done_sticky", done, 1);
        chk("done_no_access", wr_a_q.size() + rd_a_q.size(), 0);

        reset_mid();

        // Three words with two idle cycles before each
        fill_random(3);
        run_load(3, 1, 1'b0);
        reset_mid();

        // Empty image
        clear_logs();
        start = 1'b1; word_count = 15'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("zero_done_first_edge", done, 0);
        @(posedge clk); #1;
        chk("zero_done", done, 1);
        chk("zero_cpu_hold", cpu_hold, 0);
        chk("zero_checksum", checksum, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("zero_no_access", wr_a_q.size() + rd_a_q.size(), 0);
        chk("zero_sram_ceb", sram_ceb, 1);
        reset_mid();

        // Corrupted readback at address 2
        fill_random(4);
        run_load(4, 0, 1'b1);
        reset_mid();

        // start during LOAD ignored, then reset after two accepts
        fill_random(5);
        w0 = stim_q[0];
        w1 = stim_q[1];
        start = 1'b1; word_count = 15'd5;
        @(posedge clk); #1;
        start = 1'b1; word_count = 15'd1;
        in_valid = 1'b1; in_data = w0;
        @(posedge clk); #1;
        start = 1'b0;
        in_data = w1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("midload_checksum", checksum, w0 + w1);
        chk("midload_in_ready", in_ready, 1);
        chk("midload_busy", busy, 1);
        reset_mid();
        fill_random(2);
        run_load(2, 0, 1'b0);
        reset_mid();

        // Single word, then random sizes with random gaps
        fill_random(1);
        run_load(1, 2, 1'b0);
        for (int r = 0; r < 3; r++) begin
            reset_mid();
            n = $urandom_range(2, 12);
            fill_random(n);
            run_load(n, 2, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
